// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - multi-cycle restoring integer divider, signed/unsigned, with zero and overflow flags
module seq_divider #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CALC, S_FIX, S_DONE} state_t;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             signed_q, signed_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;
    logic [WIDTH:0]   r_shift;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dvd_d      = dvd_q;
        dsr_d      = dsr_q;
        d_d        = d_q;
        r_d        = r_q;
        signed_d   = signed_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        ovf_pend_d = ovf_pend_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dz_d       = dz_q;
        ov_d       = ov_q;
        // One bit wider than R so divisors above 2^(WIDTH-1) still compare correctly
        r_shift    = {r_q, d_q[WIDTH-1]};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_LOAD;
                    dvd_d    = dividend;
                    dsr_d    = divisor;
                    signed_d = is_signed;
                    dz_d     = 1'b0;
                    ov_d     = 1'b0;
                end
            end
            S_LOAD: begin
                qneg_d     = signed_q & (dvd_q[WIDTH-1] ^ dsr_q[WIDTH-1]);
                rneg_d     = signed_q & dvd_q[WIDTH-1];
                d_d        = (signed_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                dsr_d      = (signed_q && dsr_q[WIDTH-1]) ? -dsr_q : dsr_q;
                ovf_pend_d = signed_q && (dvd_q == MIN_VAL) && (dsr_q == '1);
                r_d        = '0;
                cnt_d      = CNT_INIT;
                state_d    = S_CALC;
            end
            S_CALC: begin
                if (r_shift >= {1'b0, dsr_q}) begin
                    r_d = r_shift[WIDTH-1:0] - dsr_q;
                    d_d = {d_q[WIDTH-2:0], 1'b1};
                end else begin
                    r_d = r_shift[WIDTH-1:0];
                    d_d = {d_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // dsr_q holds |divisor| here, which is zero only for a zero divisor
                if (dsr_q == '0) begin
                    quot_d = '1;
                    rem_d  = dvd_q;
                    dz_d   = 1'b1;
                end else if (ovf_pend_q) begin
                    quot_d = dvd_q;
                    rem_d  = '0;
                    ov_d   = 1'b1;
                end else begin
                    quot_d = qneg_q ? -d_q : d_q;
                    rem_d  = rneg_q ? -r_q : r_q;
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dsr_q      <= '0;
            d_q        <= '0;
            r_q        <= '0;
            signed_q   <= 1'b0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            ovf_pend_q <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
            dz_q       <= 1'b0;
            ov_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dvd_q      <= dvd_d;
            dsr_q      <= dsr_d;
            d_q        <= d_d;
            r_q        <= r_d;
            signed_q   <= signed_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            ovf_pend_q <= ovf_pend_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dz_q       <= dz_d;
            ov_q       <= ov_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dz_q;
    assign overflow    = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb/tb_seq_divider.sv - self-checking bench for seq_divider at WIDTH=16
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic         is_signed = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           due;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
    } exp_t;

    exp_t         eq[$];
    int           cyc = 0;
    int           n_checks = 0;
    int           n_errors = 0;
    int           next_ok = 0;
    int           busy_from = 0;
    int           busy_to = -1;
    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, got, want);
        end
    endfunction

    // Reference: C-style truncating division plus the two exception overrides
    function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz, output logic ov);
        int sa;
        int sb;
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = '1;
            r  = a;
            dz = 1'b1;
        end else if (s && a == 16'h8000 && b == 16'hFFFF) begin
            q  = a;
            r  = '0;
            ov = 1'b1;
        end else if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            q  = W'(sa / sb);
            r  = W'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    always @(negedge clk) begin
        if (cyc >= 1) begin
            chk("busy", 64'(busy), 64'(cyc >= busy_from && cyc <= busy_to));
            if (eq.size() > 0 && cyc == eq[0].due) begin
                chk("done_pulse", 64'(done), 64'd1);
                chk("quotient", 64'(quotient), 64'(eq[0].q));
                chk("remainder", 64'(remainder), 64'(eq[0].r));
                chk("div_by_zero", 64'(div_by_zero), 64'(eq[0].dz));
                chk("overflow", 64'(overflow), 64'(eq[0].ov));
                hold_q = eq[0].q;
                hold_r = eq[0].r;
                void'(eq.pop_front());
            end else begin
                chk("no_done", 64'(done), 64'd0);
            end
            chk("hold_quotient", 64'(quotient), 64'(hold_q));
            chk("hold_remainder", 64'(remainder), 64'(hold_r));
        end
    end

    task automatic at_cycle(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        at_cycle(next_ok);
        is_signed = s;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        model(s, a, b, e.q, e.r, e.dz, e.ov);
        e.due     = cyc + W + 3;
        busy_from = cyc + 1;
        busy_to   = e.due;
        next_ok   = cyc + W + 4;
        eq.push_back(e);
        at_cycle(cyc + 1);
        start     = 1'b0;
        dividend  = W'($urandom);
        divisor   = W'($urandom);
        is_signed = 1'($urandom);
    endtask

    task automatic run_vec(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] wq, input logic [W-1:0] wr,
                           input logic wdz, input logic wov);
        logic [W-1:0] mq;
        logic [W-1:0] mr;
        logic         mdz;
        logic         mov;
        model(s, a, b, mq, mr, mdz, mov);
        chk("model_pin", 64'({mq, mr, mdz, mov}), 64'({wq, wr, wdz, wov}));
        issue(s, a, b);
    endtask

    task automatic junk(input int t);
        at_cycle(t);
        start     = 1'b1;
        is_signed = 1'b1;
        dividend  = 16'h0BAD;
        divisor   = 16'h0003;
        at_cycle(t + 1);
        start     = 1'b0;
    endtask

    initial begin
        int acc;
        logic         rs;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        at_cycle(3);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_outputs", 64'({quotient, remainder, div_by_zero, overflow}), 64'd0);
        n_rst   = 1'b1;
        next_ok = cyc;

        run_vec(1'b0, 16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0);
        run_vec(1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0);
        run_vec(1'b0, 16'hFFF9, 16'h0002, 16'h7FFC, 16'h0001, 1'b0, 1'b0);
        run_vec(1'b0, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
        run_vec(1'b1, 16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b1, 1'b0);
        run_vec(1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b0, 1'b1);
        run_vec(1'b0, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run_vec(1'b1, 16'hFF9C, 16'h0007, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0);
        run_vec(1'b1, 16'h0064, 16'hFFF9, 16'hFFF2, 16'h0002, 1'b0, 1'b0);
        run_vec(1'b0, 16'h8000, 16'hFFFF, 16'h0000, 16'h8000, 1'b0, 1'b0);
        run_vec(1'b1, 16'h0007, 16'h0064, 16'h0000, 16'h0007, 1'b0, 1'b0);
        run_vec(1'b1, 16'h8000, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0);

        // Starts during CALC and during the DONE cycle must be ignored
        issue(1'b0, 16'd1000, 16'd9);
        acc = cyc;
        junk(acc + 2);
        junk(acc + 9);
        junk(acc + W + 2);
        issue(1'b1, 16'hFC18, 16'd9);

        // Reset part-way through an operation aborts it without a done pulse
        issue(1'b0, 16'd5000, 16'd13);
        acc = cyc;
        at_cycle(acc + 7);
        n_rst = 1'b0;
        at_cycle(acc + 8);
        n_rst   = 1'b1;
        eq.delete();
        hold_q  = '0;
        hold_r  = '0;
        busy_to = -1;
        chk("abort_flags", 64'({div_by_zero, overflow, done, busy}), 64'd0);
        next_ok = cyc;
        at_cycle(acc + W + 6);
        chk("abort_no_done_queue", 64'(eq.size()), 64'd0);
        next_ok = cyc;
        issue(1'b0, 16'd5000, 16'd13);

        for (int i = 0; i < 60; i++) begin
            rs = 1'($urandom);
            ra = W'($urandom);
            rb = W'($urandom);
            if (i % 11 == 0) rb = '0;
            if (i % 13 == 5) begin
                rs = 1'b1;
                ra = 16'h8000;
                rb = 16'hFFFF;
            end
            if (i % 4 == 1) rb = W'($urandom_range(1, 20));
            issue(rs, ra, rb);
        end

        at_cycle(next_ok + 4);
        chk("drain_queue", 64'(eq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

endmodule
